// File: rtl/vehicle_detect_if.sv
// vehicle_detect_if: farm-road sensor and light inputs plus queue status outputs
interface vehicle_detect_if #(parameter int cw = 3);
  logic          sensor_raw;
  logic          fg;
  logic          detect;
  logic [cw-1:0] vehicle_count;
  logic          starve;
  logic          overflow;
  modport master(output sensor_raw, fg, input detect, vehicle_count, starve, overflow);
  modport slave(input sensor_raw, fg, output detect, vehicle_count, starve, overflow);
endinterface

// File: rtl/vehicle_detect.sv
// vehicle_detect: debounced farm-road loop sensor feeding a saturating queue count and wait/starve FSM
module vehicle_detect #(
  parameter int debounce = 4,
  parameter int cw       = 3,
  parameter int max_wait = 64
) (
  input logic            clk,
  input logic            reset,
  vehicle_detect_if.slave bus_io
);
  typedef enum logic [1:0] {IDLE, WAIT, SERVE} state_t;
  state_t        state_q, state_d;
  logic          s1_q, s2_q, filt_q, filt_d, rise_q, rise_d, fall_q, fall_d, ovf_q, ovf_d;
  logic          hit, arrival, departure, sat;
  logic [7:0]    db_q, db_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic [15:0]   wait_q, wait_d;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      filt_q  <= 1'b0;
      db_q    <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      wait_q  <= '0;
      state_q <= IDLE;
    end else begin
      s1_q    <= bus_io.sensor_raw;
      s2_q    <= s1_q;
      filt_q  <= filt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      wait_q  <= wait_d;
      state_q <= state_d;
    end
  end
  // Edge events are registered so the count moves one cycle after the filter flips.
  always_comb begin
    hit       = (s2_q != filt_q) && (db_q == 8'(debounce - 1));
    filt_d    = hit ? ~filt_q : filt_q;
    db_d      = (s2_q == filt_q || hit) ? '0 : db_q + 8'd1;
    rise_d    = hit && !filt_q;
    fall_d    = hit && filt_q;
    arrival   = rise_q;
    departure = fall_q && bus_io.fg;
    sat       = &cnt_q;
    cnt_d     = arrival ? (sat ? cnt_q : cnt_q + 1'b1)
              : (departure && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    ovf_d     = ovf_q | (arrival & sat);
    state_d   = bus_io.fg ? SERVE : (cnt_d != '0 ? WAIT : IDLE);
    wait_d    = state_q == WAIT ? (wait_q == 16'(max_wait) ? wait_q : wait_q + 16'd1) : '0;
  end
  assign bus_io.detect        = cnt_q != '0;
  assign bus_io.vehicle_count = cnt_q;
  assign bus_io.starve        = (state_q == WAIT) && (wait_q == 16'(max_wait));
  assign bus_io.overflow      = ovf_q;
endmodule

// File: tb/tb_vehicle_detect.sv
// tb_vehicle_detect: directed checks of debounce latency, queue counting, starve and reset behaviour
module tb_vehicle_detect;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  vehicle_detect_if #(.cw(3)) bus();
  vehicle_detect #(.debounce(4), .cw(3), .max_wait(64)) dut(.clk(clk), .reset(reset), .bus_io(bus));
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.sensor_raw = 1'b0;
    bus.fg = 1'b0;
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic pulse();
    bus.sensor_raw = 1'b1;
    tick(8);
    bus.sensor_raw = 1'b0;
    tick(8);
  endtask

  task automatic test_reset();
    bus.sensor_raw = 1'b0;
    bus.fg = 1'b0;
    reset = 1'b0;
    tick(2);
    checks++;
    if ({bus.detect, bus.vehicle_count, bus.starve, bus.overflow} !== 6'b0) begin
      errors++;
      $display("FAIL reset_hold: got %b expected 000000", {bus.detect, bus.vehicle_count, bus.starve, bus.overflow});
    end
    reset = 1'b1;
    tick(1);
    checks++;
    if ({bus.detect, bus.vehicle_count, bus.starve, bus.overflow} !== 6'b0) begin
      errors++;
      $display("FAIL reset_release: got %b expected 000000", {bus.detect, bus.vehicle_count, bus.starve, bus.overflow});
    end
  endtask

  task automatic test_latency();
    bus.sensor_raw = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      checks++;
      if (bus.detect !== (i >= 7)) begin
        errors++;
        $display("FAIL latency edge %0d: detect %b expected %b", i - 1, bus.detect, i >= 7);
      end
    end
    checks++;
    if (bus.vehicle_count !== 3'd1) begin
      errors++;
      $display("FAIL latency_count: got %0d expected 1", bus.vehicle_count);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int w = 1; w <= 3; w++) begin
      bus.sensor_raw = 1'b1;
      tick(w);
      bus.sensor_raw = 1'b0;
      tick(3);
    end
    tick(6);
    checks++;
    if (bus.vehicle_count !== 3'd0 || bus.detect !== 1'b0) begin
      errors++;
      $display("FAIL bounce: count %0d detect %b expected 0 0", bus.vehicle_count, bus.detect);
    end
  endtask

  task automatic test_departure();
    do_reset();
    for (int n = 1; n <= 2; n++) begin
      pulse();
      checks++;
      if (bus.vehicle_count !== 3'(n)) begin
        errors++;
        $display("FAIL arrival_%0d: count %0d expected %0d", n, bus.vehicle_count, n);
      end
    end
    bus.sensor_raw = 1'b1;
    tick(8);
    checks++;
    if (bus.vehicle_count !== 3'd3) begin
      errors++;
      $display("FAIL arrival_3: count %0d expected 3", bus.vehicle_count);
    end
    bus.fg = 1'b1;
    tick(1);
    bus.sensor_raw = 1'b0;
    tick(8);
    checks++;
    if (bus.vehicle_count !== 3'd2 || bus.detect !== 1'b1) begin
      errors++;
      $display("FAIL departure: count %0d detect %b expected 2 1", bus.vehicle_count, bus.detect);
    end
    bus.sensor_raw = 1'b1;
    tick(8);
    checks++;
    if (bus.vehicle_count !== 3'd3) begin
      errors++;
      $display("FAIL green_arrival: count %0d expected 3", bus.vehicle_count);
    end
    bus.sensor_raw = 1'b0;
    tick(8);
    checks++;
    if (bus.vehicle_count !== 3'd2) begin
      errors++;
      $display("FAIL green_departure: count %0d expected 2", bus.vehicle_count);
    end
    do_reset();
    bus.sensor_raw = 1'b1;
    tick(8);
    bus.fg = 1'b1;
    bus.sensor_raw = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      checks++;
      if (bus.detect !== (i < 7)) begin
        errors++;
        $display("FAIL detect_fall edge %0d: detect %b expected %b", i - 1, bus.detect, i < 7);
      end
    end
  endtask

  task automatic test_starve();
    bit found = 1'b0;
    do_reset();
    bus.sensor_raw = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      found = bus.detect;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL starve_arrival: detect 0 expected 1 within 20 cycles");
    end
    tick(63);
    checks++;
    if (bus.starve !== 1'b0) begin
      errors++;
      $display("FAIL starve_early: got %b expected 0", bus.starve);
    end
    tick(1);
    checks++;
    if (bus.starve !== 1'b1) begin
      errors++;
      $display("FAIL starve_on: got %b expected 1", bus.starve);
    end
    bus.fg = 1'b1;
    tick(1);
    checks++;
    if (bus.starve !== 1'b0) begin
      errors++;
      $display("FAIL starve_clear: got %b expected 0", bus.starve);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.sensor_raw = 1'b1;
    tick(6);
    bus.fg = 1'b1;
    tick(1);
    checks++;
    if (bus.vehicle_count !== 3'd1) begin
      errors++;
      $display("FAIL fg_with_arrival: count %0d expected 1", bus.vehicle_count);
    end
    bus.fg = 1'b0;
    tick(64);
    checks++;
    if (bus.starve !== 1'b0) begin
      errors++;
      $display("FAIL serve_to_wait_early: starve %b expected 0", bus.starve);
    end
    tick(1);
    checks++;
    if (bus.starve !== 1'b1) begin
      errors++;
      $display("FAIL serve_to_wait: starve %b expected 1", bus.starve);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int n = 1; n <= 8; n++) begin
      pulse();
      checks++;
      if (bus.vehicle_count !== 3'(n > 7 ? 7 : n) || bus.overflow !== (n == 8)) begin
        errors++;
        $display("FAIL overflow_arrival_%0d: count %0d ovf %b expected %0d %b", n, bus.vehicle_count, bus.overflow, n > 7 ? 7 : n, n == 8);
      end
    end
    bus.fg = 1'b1;
    tick(20);
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b expected 1", bus.overflow);
    end
    do_reset();
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_reset: got %b expected 0", bus.overflow);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse();
    pulse();
    tick(70);
    checks++;
    if (bus.vehicle_count !== 3'd2 || bus.starve !== 1'b1) begin
      errors++;
      $display("FAIL pre_async: count %0d starve %b expected 2 1", bus.vehicle_count, bus.starve);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.detect, bus.vehicle_count, bus.starve} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset: got %b expected 00000", {bus.detect, bus.vehicle_count, bus.starve});
    end
    tick(1);
    reset = 1'b1;
  endtask

  task automatic test_rearrival();
    bus.sensor_raw = 1'b1;
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      checks++;
      if (bus.detect !== (i >= 7)) begin
        errors++;
        $display("FAIL rearrival edge %0d: detect %b expected %b", i - 1, bus.detect, i >= 7);
      end
    end
  endtask

  initial begin
    bus.sensor_raw = 1'b0;
    bus.fg = 1'b0;
    test_reset();
    test_latency();
    test_bounce();
    test_departure();
    test_starve();
    test_back_to_back();
    test_overflow();
    test_async_reset();
    test_rearrival();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
